// File: rtl/arbitro_fpu.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_fpu
// Description : Two-port round-robin arbiter/sequencer for a shared 32-bit
//               FPU. Resolves zero-operand requests locally, waits for the
//               FPU's completion status with a timeout, returns the result to
//               the owning port and then pulses the FPU back to idle.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_fpu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock_100KHz,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_op_A,
    input  logic [31:0] req0_op_B,
    input  logic [31:0] req1_op_A,
    input  logic [31:0] req1_op_B,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_data,
    output logic [3:0]  resp_status,
    output logic [31:0] fpu_op_A,
    output logic [31:0] fpu_op_B,
    output logic        fpu_reset,
    input  logic [3:0]  fpu_status_in,
    input  logic [31:0] fpu_data_in
);

    localparam int              CW          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]   C_CNT_MAX   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      C_ST_EXACT  = 4'b0001;
    localparam logic [3:0]      C_ST_TMO    = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT     = 3'd1,
        S_RESP     = 3'd2,
        S_CLEAR    = 3'd3,
        S_RESP_BYP = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_last_grant;   // 1: port 1 was served last
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_fpu_op_A;
    logic [31:0]   r_fpu_op_B;
    logic [31:0]   r_resp_data;
    logic [3:0]    r_resp_status;
    logic          r_resp0_valid;
    logic          r_resp1_valid;

    logic          w_grant0;
    logic          w_grant1;
    logic [31:0]   w_op_a;
    logic [31:0]   w_op_b;
    logic          w_a_zero;
    logic          w_b_zero;

    // Round-robin grant: on a tie the port that was not served last wins.
    // Ready is suppressed during reset so no request is accepted then.
    assign w_grant0 = (r_state == S_IDLE) && !reset && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = (r_state == S_IDLE) && !reset && req1_valid && (!req0_valid || !r_last_grant);
    assign w_op_a   = w_grant1 ? req1_op_A : req0_op_A;
    assign w_op_b   = w_grant1 ? req1_op_B : req0_op_B;
    assign w_a_zero = (w_op_a == 32'h0);
    assign w_b_zero = (w_op_b == 32'h0);

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp_data   = r_resp_data;
    assign resp_status = r_resp_status;
    assign fpu_op_A    = r_fpu_op_A;
    assign fpu_op_B    = r_fpu_op_B;
    // Active-low FPU reset: held low through our reset and pulsed low in CLEAR.
    assign fpu_reset   = !reset && (r_state != S_CLEAR);

    // Sequencer: accept, run or bypass, respond, and clear the FPU.
    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_cnt         <= '0;
            r_fpu_op_A    <= 32'h0;
            r_fpu_op_B    <= 32'h0;
            r_resp_data   <= 32'h0;
            r_resp_status <= 4'h0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_fpu_op_A <= 32'h0;
                    r_fpu_op_B <= 32'h0;
                    if (w_grant0 || w_grant1) begin
                        r_last_grant <= w_grant1;
                        r_owner      <= w_grant1;
                        if (w_a_zero || w_b_zero) begin
                            // Zero operand: answer with the other operand, FPU untouched
                            r_resp_data   <= w_a_zero ? w_op_b : w_op_a;
                            r_resp_status <= C_ST_EXACT;
                            r_resp0_valid <= w_grant0;
                            r_resp1_valid <= w_grant1;
                            r_state       <= S_RESP_BYP;
                        end else begin
                            r_fpu_op_A <= w_op_a;
                            r_fpu_op_B <= w_op_b;
                            r_cnt      <= '0;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (fpu_status_in != 4'h0) begin
                        r_resp_data   <= fpu_data_in;
                        r_resp_status <= fpu_status_in;
                        r_resp0_valid <= !r_owner;
                        r_resp1_valid <= r_owner;
                        r_state       <= S_RESP;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_resp_data   <= 32'h0;
                        r_resp_status <= C_ST_TMO;
                        r_resp0_valid <= !r_owner;
                        r_resp1_valid <= r_owner;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    // Operands drop together with the FPU reset pulse
                    r_fpu_op_A <= 32'h0;
                    r_fpu_op_B <= 32'h0;
                    r_state    <= S_CLEAR;
                end
                S_CLEAR:    r_state <= S_IDLE;
                S_RESP_BYP: r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_fpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_fpu
// Description : Scoreboard bench for arbitro_fpu with a small FPU model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_arbitro_fpu;

    localparam int C_TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_op_A, req0_op_B, req1_op_A, req1_op_B;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp_data, fpu_op_A, fpu_op_B, fpu_data_in;
    logic [3:0]  resp_status, fpu_status_in;
    logic        fpu_reset;

    arbitro_fpu #(.TIMEOUT_CYCLES(C_TMO)) u_dut (
        .clock_100KHz (clk),
        .reset        (rst),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_op_A    (req0_op_A),
        .req0_op_B    (req0_op_B),
        .req1_op_A    (req1_op_A),
        .req1_op_B    (req1_op_B),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .resp0_valid  (resp0_valid),
        .resp1_valid  (resp1_valid),
        .resp_data    (resp_data),
        .resp_status  (resp_status),
        .fpu_op_A     (fpu_op_A),
        .fpu_op_B     (fpu_op_B),
        .fpu_reset    (fpu_reset),
        .fpu_status_in(fpu_status_in),
        .fpu_data_in  (fpu_data_in)
    );

    always #5 clk = ~clk;

    // FPU model: completes fpu_dly cycles after operands appear
    int          fpu_dly   = 3;
    logic [3:0]  fpu_st    = 4'b0001;
    logic [31:0] fpu_dat   = 32'h40500000;
    bit          fpu_never = 1'b0;
    int          fpu_cnt   = 0;

    always @(posedge clk) begin
        if (!fpu_reset || fpu_op_A == 32'h0) fpu_cnt <= 0;
        else if (fpu_cnt < 1000)             fpu_cnt <= fpu_cnt + 1;
    end
    assign fpu_status_in = (fpu_reset && fpu_op_A != 32'h0 && !fpu_never && fpu_cnt >= fpu_dly) ? fpu_st : 4'h0;
    assign fpu_data_in   = (fpu_status_in != 4'h0) ? fpu_dat : 32'hDEADBEEF;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [3:0]  st;
        int          lat;
        bit          byp;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   grant_log[$];
    int   n_ready1 = 0;
    bit   pending_clear = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pushes expectations on accept, pops and compares on response
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a, b;
        if (pending_clear) begin
            chk("clear_fpu_reset", 32'(fpu_reset), 32'h0);
            chk("clear_fpu_op", fpu_op_A | fpu_op_B, 32'h0);
            pending_clear = 1'b0;
        end
        if (req0_ready || req1_ready) begin
            chk("ready_excl", 32'(req0_ready & req1_ready), 32'h0);
            e.port = req1_ready ? 1 : 0;
            a = req1_ready ? req1_op_A : req0_op_A;
            b = req1_ready ? req1_op_B : req0_op_B;
            e.cyc = cyc;
            if (a == 32'h0 || b == 32'h0) begin
                e.byp = 1'b1; e.data = (a == 32'h0) ? b : a; e.st = 4'b0001; e.lat = 1;
            end else if (fpu_never) begin
                e.byp = 1'b0; e.data = 32'h0; e.st = 4'b1111; e.lat = 1 + C_TMO;
            end else begin
                e.byp = 1'b0; e.data = fpu_dat; e.st = fpu_st; e.lat = 2 + fpu_dly;
            end
            q.push_back(e);
            grant_log.push_back(e.port);
            if (req1_ready) n_ready1++;
        end
        if (resp0_valid || resp1_valid) begin
            chk("resp_excl", 32'(resp0_valid & resp1_valid), 32'h0);
            if (q.size() == 0) begin
                chk("resp_unexpected", 32'(resp1_valid), 32'hFFFFFFFF);
            end else begin
                e = q.pop_front();
                chk("resp_port", 32'(resp1_valid), 32'(e.port));
                chk("resp_data", resp_data, e.data);
                chk("resp_status", 32'(resp_status), 32'(e.st));
                chk("resp_latency", 32'(cyc - e.cyc), 32'(e.lat));
                if (e.byp) chk("byp_fpu_idle", fpu_op_A | fpu_op_B, 32'h0);
                else       pending_clear = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int port, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        if (port == 0) begin req0_op_A = a; req0_op_B = b; req0_valid = 1'b1; end
        else           begin req1_op_A = a; req1_op_B = b; req1_valid = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'(port), 32'hFFFFFFFF);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("idle_timeout", 32'(q.size()), 32'h0);
        step(3);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op_A = 32'h0; req0_op_B = 32'h0; req1_op_A = 32'h0; req1_op_B = 32'h0;

        // Reset state with both requesters already pending
        req0_op_A = 32'h3F800000; req0_op_B = 32'h40000000; req0_valid = 1'b1;
        req1_op_A = 32'h40400000; req1_op_B = 32'h40800000; req1_valid = 1'b1;
        step(3);
        @(negedge clk);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'h0);
        chk("rst_resp_valid", 32'({resp0_valid, resp1_valid}), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_status", 32'(resp_status), 32'h0);
        chk("rst_fpu_op", fpu_op_A | fpu_op_B, 32'h0);
        chk("rst_fpu_reset", 32'(fpu_reset), 32'h0);
        step(1);

        // Tie arbitration from reset
        fpu_dly = 3; fpu_st = 4'b0001; fpu_dat = 32'h40500000;
        base = grant_log.size();
        rst = 1'b0;
        fork
            begin send(0, 32'h3F800000, 32'h40000000); send(0, 32'h3F800001, 32'h40000001); end
            begin send(1, 32'h40400000, 32'h40800000); send(1, 32'h40400001, 32'h40800001); end
        join
        wait_idle();
        chk("tie_count", 32'(grant_log.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (base + i < grant_log.size()) chk("tie_order", 32'(grant_log[base+i]), 32'(i % 2));

        // Single FPU request
        fpu_dly = 5;
        send(0, 32'h3FC00000, 32'h3FA00000);
        wait_idle();

        // Zero bypass
        send(1, 32'h0, 32'hC0200000);
        wait_idle();
        send(1, 32'h0, 32'h0);
        wait_idle();
        send(0, 32'h80000000, 32'h40000000);   // negative zero is not zero
        wait_idle();

        // Timeout then a normal request
        fpu_never = 1'b1;
        send(0, 32'h3F800000, 32'h3F800000);
        wait_idle();
        fpu_never = 1'b0; fpu_dly = 2;
        send(1, 32'h3F800000, 32'h3F800000);
        wait_idle();

        // Status pass-through with a withdrawn request on port 1
        fpu_st = 4'b1010; fpu_dly = 5;
        base = n_ready1;
        fork
            send(0, 32'h41000000, 32'h41100000);
            begin
                step(2);
                req1_op_A = 32'h3F800000; req1_op_B = 32'h3F800000; req1_valid = 1'b1;
                step(3);
                req1_valid = 1'b0;
            end
        join
        wait_idle();
        chk("withdraw_no_ready1", 32'(n_ready1), 32'(base));

        // Reset in the middle of WAIT
        fpu_st = 4'b0001; fpu_never = 1'b1;
        send(0, 32'h3F800000, 32'h40000000);
        step(2);
        rst = 1'b1;
        q.delete();
        pending_clear = 1'b0;
        step(1);
        @(negedge clk);
        chk("mid_rst_resp_valid", 32'({resp0_valid, resp1_valid}), 32'h0);
        chk("mid_rst_resp_data", resp_data, 32'h0);
        chk("mid_rst_resp_status", 32'(resp_status), 32'h0);
        chk("mid_rst_fpu_op", fpu_op_A | fpu_op_B, 32'h0);
        chk("mid_rst_fpu_reset", 32'(fpu_reset), 32'h0);
        step(2);
        fpu_never = 1'b0; fpu_dly = 3;
        base = grant_log.size();
        rst = 1'b0;
        fork
            send(0, 32'h40A00000, 32'h40C00000);
            send(1, 32'h40E00000, 32'h41000000);
        join
        wait_idle();
        chk("post_rst_count", 32'(grant_log.size() - base), 32'd2);
        if (grant_log.size() > base) chk("post_rst_first", 32'(grant_log[base]), 32'd0);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
